// File: rtl/pc_fetch_stage.sv
// IF stage: PC register, next-PC select and IF/ID register; one-cycle fetch latency.
// stall holds PC and IF/ID (IRQ/exception vectoring still proceeds); flush injects a NOP.
// Define SUPERVISOR_PROTECT_EN to clear jr/jalr target bit 31 when running in user mode.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        supervise
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jr_eff;
  logic [31:0] next_pc;
  logic        vectoring;

  assign imem_addr = pc;

  // Increment never crosses the user/kernel boundary held in bit 31.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

`ifdef SUPERVISOR_PROTECT_EN
  assign jr_eff = {jr_target[31] & pc[31], jr_target[30:0]};
`else
  assign jr_eff = jr_target;
`endif

  assign vectoring = (pc_src == 3'b100) || (pc_src == 3'b101);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      3'b001:  next_pc = branch_taken ? branch_target : pc_plus4;
      3'b010:  next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      3'b011:  next_pc = jr_eff;
      3'b100:  next_pc = IRQ_VECTOR;
      3'b101:  next_pc = EXC_VECTOR;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (vectoring || !stall) begin
      pc <= next_pc;
    end
  end

  // A flushed slot still carries PC+4 and mode so a later link/return stays meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instruction <= 32'h0;
      ifid_pc_plus4    <= RESET_PC;
      ifid_valid       <= 1'b0;
      supervise        <= RESET_PC[31];
    end else if (flush) begin
      ifid_instruction <= 32'h0;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b0;
      supervise        <= pc[31];
    end else if (!stall) begin
      ifid_instruction <= imem_data;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
      supervise        <= pc[31];
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Randomized and directed checks of pc_fetch_stage against a behavioural fetch model.
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        supervise;

  logic        force_en;
  logic [31:0] force_val;

  int checks;
  int errors;

  // Behavioural model state
  logic [31:0] mpc;
  logic [31:0] m_inst;
  logic [31:0] m_p4;
  logic        m_vld;
  logic        m_sup;

  pc_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .pc_src           (pc_src),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump_index       (jump_index),
    .jr_target        (jr_target),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .supervise        (supervise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_data = force_en ? force_val : mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [2:0] src,
                      input logic bt, input logic [31:0] btgt, input logic [25:0] ji,
                      input logic [31:0] jr);
    logic [31:0] p4, tgt, word;
    logic        vec;
    reset = r; stall = s; flush = f; pc_src = src;
    branch_taken = bt; branch_target = btgt; jump_index = ji; jr_target = jr;

    p4   = (mpc & 32'h8000_0000) | ((mpc + 32'd4) & 32'h7FFF_FFFF);
    word = force_en ? force_val : mem_word(mpc);
    vec  = (src == 3'd4) || (src == 3'd5);
    case (src)
      3'd1: tgt = bt ? btgt : p4;
      3'd2: tgt = (p4 & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
      3'd3: begin
`ifdef SUPERVISOR_PROTECT_EN
        tgt = mpc[31] ? jr : (jr & 32'h7FFF_FFFF);
`else
        tgt = jr;
`endif
      end
      3'd4: tgt = 32'h8000_0004;
      3'd5: tgt = 32'h8000_0008;
      default: tgt = p4;
    endcase

    @(posedge clk);
    #1;
    if (r) begin
      m_inst = 32'h0; m_p4 = 32'h8000_0000; m_vld = 1'b0; m_sup = 1'b1;
      mpc = 32'h8000_0000;
    end else begin
      if (f) begin
        m_inst = 32'h0; m_p4 = p4; m_vld = 1'b0; m_sup = mpc[31];
      end else if (!s) begin
        m_inst = word; m_p4 = p4; m_vld = 1'b1; m_sup = mpc[31];
      end
      if (vec || !s) mpc = tgt;
    end
    check("imem_addr", imem_addr, mpc);
    check("ifid_instruction", ifid_instruction, m_inst);
    check("ifid_pc_plus4", ifid_pc_plus4, m_p4);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_vld});
    check("supervise", {31'd0, supervise}, {31'd0, m_sup});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, a);
  endtask

  initial begin
    checks = 0; errors = 0;
    force_en = 1'b0; force_val = 32'h0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 3'd0;
    branch_taken = 1'b0; branch_target = 32'h0; jump_index = 26'h0; jr_target = 32'h0;
    mpc = 32'h0; m_inst = 32'h0; m_p4 = 32'h0; m_vld = 1'b0; m_sup = 1'b0;

    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    check("reset_pc", imem_addr, 32'h8000_0000);
    check("reset_valid", {31'd0, ifid_valid}, 32'd0);
    idle();
    check("run1_addr", imem_addr, 32'h8000_0004);
    check("run1_valid", {31'd0, ifid_valid}, 32'd1);
    idle();
    check("run2_addr", imem_addr, 32'h8000_0008);

    goto_pc(32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 32'h0000_0040, 26'h0, 32'h0);
    check("branch_taken", imem_addr, 32'h0000_0040);
    goto_pc(32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0000_0040, 26'h0, 32'h0);
    check("branch_not_taken", imem_addr, 32'h0000_0014);

    goto_pc(32'h1000_0000);
    step(1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 32'h0, 26'h000_0100, 32'h0);
    check("jump", imem_addr, 32'h1000_0400);

    goto_pc(32'h0000_0020);
    idle();
    goto_pc(32'h0000_0020);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    check("stall_hold", imem_addr, 32'h0000_0020);
    step(1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    check("stall_irq", imem_addr, 32'h8000_0004);
    idle();
    check("irq_supervise", {31'd0, supervise}, 32'd1);

    force_en = 1'b1; force_val = 32'h2002_0005;
    step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    force_en = 1'b0;
    check("flush_inst", ifid_instruction, 32'h0);
    check("flush_p4", ifid_pc_plus4, 32'h8000_000C);

    goto_pc(32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h8000_0200);
`ifdef SUPERVISOR_PROTECT_EN
    check("jr_user", imem_addr, 32'h0000_0200);
`else
    check("jr_user", imem_addr, 32'h8000_0200);
`endif

    step(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0);
    check("reset_mid_redirect", imem_addr, 32'h8000_0000);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] jr;
      jr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) jr = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFC : 32'hFFFF_FFF8;
      force_en = ($urandom_range(0, 9) == 0);
      force_val = $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
           26'($urandom), jr);
    end
    force_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
